card_shoe: RTL and testbench
============================

Name: card_shoe

Overview:
- Card source for the blackjack datapath: a 52-card single-deck shoe, dealt without replacement.
- It answers the FSM's card request handshake: the shoe asserts RDY and presents a card; the FSM pulses USED to consume it.
- Drop-in alternative to the free-running random card generator. It gives realistic deck statistics: each rank appears exactly 4 times per deck.
- The deck is filled, then shuffled in hardware with Fisher-Yates, then dealt sequentially.

Parameters:
- SEED, 16'hACE1, reset value of the internal 16-bit LFSR; must be nonzero.
- AUTO_RESHUF, 1'b1, 1 = when the deck is exhausted, reshuffle automatically; 0 = stop in EMPTY until SHUFFLE.

Ports:
- CLK  input  1  system clock; all state changes on posedge.
- RST  input  1  asynchronous, active-high reset.
- USED  input  1  consumer has taken the presented card; honoured only when RDY=1.
- SHUFFLE  input  1  single-cycle request to refill and reshuffle; honoured in DEAL or EMPTY only.
- RND  output  4  presented card rank, 1..13 (1=A, 11=J, 12=Q, 13=K); valid only while RDY=1.
- RDY  output  1  a card is presented and may be consumed.
- BUSY  output  1  fill or shuffle in progress.
- EMPTY  output  1  deck exhausted; only in EMPTY state (AUTO_RESHUF=0).
- REMAIN  output  6  number of undealt cards, 0..52.

Behaviour:
- Reset values (asynchronous): state=FILL, RND=0, RDY=0, BUSY=1, EMPTY=0, REMAIN=0, LFSR=SEED, deck contents don't-care.
- LFSR:
  - Galois, taps 16'hB400.
  - Advances every cycle in every state, so shuffle outcome depends on when the shuffle starts.
- Deck storage: 52 x 4-bit register array; dealing pointer ptr (6 bit).
- FILL state:
  - Lasts exactly 52 cycles; cycle k writes deck[k] = (k mod 13)+1.
  - Then goes to SHUF with i=51.
- SHUF state:
  - Each cycle, candidate j = LFSR[5:0].
  - If j <= i: swap deck[i] and deck[j] in one cycle, then i <= i-1.
  - Otherwise reject and retry next cycle; i is unchanged.
  - When a swap is accepted with i==1: go to DEAL with ptr=0 and REMAIN=52.
  - On DEAL entry, BUSY falls and RDY rises in the same cycle.
- DEAL state:
  - RDY=1 whenever REMAIN>0 and the previous cycle was not a consume.
  - RND=deck[ptr], registered and held stable while RDY=1.
  - Consume = USED & RDY at a clock edge. It causes ptr+1, REMAIN-1 and RDY=0 for exactly the next cycle.
  - After that cycle, RDY=1 with the new card.
  - USED held high continuously therefore yields one card every 2 cycles.
  - USED while RDY=0 is ignored; no card is lost.
- Exhaustion: the consume that takes REMAIN from 1 to 0 leads to:
  - AUTO_RESHUF=1: next state FILL, BUSY=1, RDY=0.
  - AUTO_RESHUF=0: next state EMPTY, EMPTY=1, RDY=0, RND holds its last value.
- EMPTY state: exits only on SHUFFLE, going to FILL with EMPTY=0.
- SHUFFLE:
  - In DEAL or EMPTY: next state FILL, REMAIN=0, RDY=0 next cycle.
  - If asserted together with a consume, SHUFFLE wins and the consume is discarded.
  - Ignored in FILL and SHUF.
- RST mid-shuffle or mid-deal: immediate return to reset values; the full fill and shuffle restarts.
- Invariant: cards dealt between two DEAL entries are a permutation of 4 copies of ranks 1..13.

Test Plan:
- RST pulse, then wait -> BUSY=1 for at least 103 cycles (52 fill + 51 accepted swaps). Then RDY=1, BUSY=0, REMAIN=52, RND in 1..13.
- Consume 52 cards with single USED pulses -> histogram shows exactly 4 of each rank 1..13. REMAIN decrements 52..0. RDY low exactly one cycle after each consume.
- Hold USED=1 for 20 cycles from the first RDY -> exactly 10 cards consumed; REMAIN=42; RND stable whenever RDY=1.
- AUTO_RESHUF=0, deal all 52 -> EMPTY=1, RDY=0, further USED ignored. Then SHUFFLE pulse -> EMPTY=0, BUSY=1, later REMAIN=52, RDY=1.
- AUTO_RESHUF=1, deal all 52 -> BUSY=1 the cycle after the last consume, later RDY=1 and REMAIN=52. The second deck's order differs from the first.
- SHUFFLE and USED together at REMAIN=30 -> no card consumed, BUSY=1. RST asserted mid-SHUF -> outputs go to reset values immediately, and the 52-cycle FILL restarts.

Source files
------------

// File: rtl/card_shoe.sv
// Single-deck 52-card shoe: fills ranks 1..13 four times, Fisher-Yates shuffles with an LFSR,
// then deals sequentially through a RDY/USED handshake.
module card_shoe #(
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter bit          AUTO_RESHUF = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       USED,
    input  logic       SHUFFLE,
    output logic [3:0] RND,
    output logic       RDY,
    output logic       BUSY,
    output logic       EMPTY,
    output logic [5:0] REMAIN
);

    typedef enum logic [1:0] {StFill, StShuf, StDeal, StEmpty} state_e;

    state_e      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [3:0]  deck_q [52];
    logic [3:0]  deck_d [52];
    logic [5:0]  cnt_q, cnt_d;     // fill index k in StFill, Fisher-Yates index i in StShuf
    logic [3:0]  rank_q, rank_d;
    logic [5:0]  ptr_q, ptr_d;
    logic [5:0]  remain_q, remain_d;
    logic        rdy_q, rdy_d;
    logic [3:0]  rnd_q, rnd_d;

    logic [5:0] j;
    logic       accept;
    logic       consume;

    assign j       = lfsr_q[5:0];
    assign accept  = (j <= cnt_q);
    assign consume = USED & rdy_q;
    assign lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= StFill;
            lfsr_q   <= SEED;
            cnt_q    <= 6'd0;
            rank_q   <= 4'd1;
            ptr_q    <= 6'd0;
            remain_q <= 6'd0;
            rdy_q    <= 1'b0;
            rnd_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            cnt_q    <= cnt_d;
            rank_q   <= rank_d;
            ptr_q    <= ptr_d;
            remain_q <= remain_d;
            rdy_q    <= rdy_d;
            rnd_q    <= rnd_d;
        end
    end

    // Deck contents are rebuilt by every fill, so they need no reset
    always_ff @(posedge CLK) begin
        deck_q <= deck_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFill:  if (cnt_q == 6'd51) state_d = StShuf;
            StShuf:  if (accept && cnt_q == 6'd1) state_d = StDeal;
            StDeal: begin
                if (SHUFFLE) begin
                    state_d = StFill;
                end else if (consume && remain_q == 6'd1) begin
                    state_d = AUTO_RESHUF ? StFill : StEmpty;
                end
            end
            StEmpty: if (SHUFFLE) state_d = StFill;
        endcase
    end

    // Datapath next-state
    always_comb begin
        deck_d   = deck_q;
        cnt_d    = cnt_q;
        rank_d   = rank_q;
        ptr_d    = ptr_q;
        remain_d = remain_q;
        rdy_d    = rdy_q;
        rnd_d    = rnd_q;
        unique case (state_q)
            StFill: begin
                deck_d[cnt_q] = rank_q;
                cnt_d         = (cnt_q == 6'd51) ? 6'd51 : cnt_q + 6'd1;
                rank_d        = (rank_q == 4'd13) ? 4'd1 : rank_q + 4'd1;
            end
            StShuf: begin
                if (accept) begin
                    deck_d[cnt_q] = deck_q[j];
                    deck_d[j]     = deck_q[cnt_q];
                    cnt_d         = cnt_q - 6'd1;
                    if (cnt_q == 6'd1) begin
                        ptr_d    = 6'd0;
                        remain_d = 6'd52;
                        rdy_d    = 1'b1;
                        // first card must reflect the final swap
                        rnd_d    = deck_d[0];
                    end
                end
            end
            StDeal: begin
                if (SHUFFLE) begin
                    cnt_d    = 6'd0;
                    rank_d   = 4'd1;
                    remain_d = 6'd0;
                    rdy_d    = 1'b0;
                end else if (consume) begin
                    ptr_d    = ptr_q + 6'd1;
                    remain_d = remain_q - 6'd1;
                    rdy_d    = 1'b0;
                    if (remain_q == 6'd1) begin
                        cnt_d  = 6'd0;
                        rank_d = 4'd1;
                    end
                end else if (!rdy_q) begin
                    rdy_d = 1'b1;
                    rnd_d = deck_q[ptr_q];
                end
            end
            StEmpty: begin
                if (SHUFFLE) begin
                    cnt_d    = 6'd0;
                    rank_d   = 4'd1;
                    remain_d = 6'd0;
                    rdy_d    = 1'b0;
                end
            end
        endcase
    end

    // Outputs
    always_comb begin
        BUSY   = (state_q == StFill) || (state_q == StShuf);
        EMPTY  = (state_q == StEmpty);
        RND    = rnd_q;
        RDY    = rdy_q;
        REMAIN = remain_q;
    end

endmodule

// File: tb/tb_card_shoe.sv
// Bench for card_shoe: two instances (auto-reshuffle on/off) checked against a
// Fisher-Yates reference model driven by the same LFSR sequence.
module tb_card_shoe;

    localparam logic [15:0] Seed = 16'hACE1;

    logic       CLK, RST;
    logic       used_a, shuffle_a, used_e, shuffle_e;
    logic [3:0] rnd_a, rnd_e;
    logic       rdy_a, rdy_e, busy_a, busy_e, empty_a, empty_e;
    logic [5:0] remain_a, remain_e;

    int total = 0;
    int bad = 0;
    int cyc;
    int pred[52];
    int pred_last;
    int deck1[52];
    int first_cards[8];
    int hist[14];

    card_shoe #(.SEED(Seed), .AUTO_RESHUF(1'b1)) dut_a (
        .CLK(CLK), .RST(RST), .USED(used_a), .SHUFFLE(shuffle_a), .RND(rnd_a), .RDY(rdy_a),
        .BUSY(busy_a), .EMPTY(empty_a), .REMAIN(remain_a)
    );

    card_shoe #(.SEED(Seed), .AUTO_RESHUF(1'b0)) dut_e (
        .CLK(CLK), .RST(RST), .USED(used_e), .SHUFFLE(shuffle_e), .RND(rnd_e), .RDY(rdy_e),
        .BUSY(busy_e), .EMPTY(empty_e), .REMAIN(remain_e)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Edge index since reset release: edge n sees LFSR = SEED stepped n times
    always @(posedge CLK or posedge RST) begin
        if (RST) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lstep(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    // Deck order and last-swap edge for a fill whose first cycle is edge 'start'
    task automatic predict(input int start);
        logic [15:0] l;
        int i, j, e, t;
        for (int k = 0; k < 52; k++) pred[k] = (k % 13) + 1;
        l = Seed;
        for (int n = 0; n < start + 52; n++) l = lstep(l);
        e = start + 52;
        i = 51;
        pred_last = -1;
        while (i >= 1 && e < start + 52 + 20000) begin
            j = int'(l[5:0]);
            if (j <= i) begin
                t = pred[i]; pred[i] = pred[j]; pred[j] = t;
                if (i == 1) pred_last = e;
                i--;
            end
            l = lstep(l);
            e++;
        end
    endtask

    task automatic wait_rdy(input bit sel);
        int n = 0;
        while (!(sel ? rdy_a : rdy_e) && n < 3000) begin
            tick();
            n++;
        end
        chk("rdy_timeout", sel ? rdy_a : rdy_e, 1);
    endtask

    task automatic deal_one(input bit sel, input int exp_rnd, input int exp_rem,
                            output int e, output int got);
        chk("deal_rdy", sel ? rdy_a : rdy_e, 1);
        chk("deal_rnd", sel ? rnd_a : rnd_e, exp_rnd);
        got = int'(sel ? rnd_a : rnd_e);
        if (sel) used_a = 1'b1; else used_e = 1'b1;
        e = cyc;
        tick();
        used_a = 1'b0;
        used_e = 1'b0;
        chk("deal_rdy_low", sel ? rdy_a : rdy_e, 0);
        chk("deal_remain", sel ? remain_a : remain_e, exp_rem);
    endtask

    initial begin
        int e, got, ncons, diff;
        RST = 1'b1;
        used_a = 0; shuffle_a = 0; used_e = 0; shuffle_e = 0;
        for (int r = 0; r < 14; r++) hist[r] = 0;
        #1;
        chk("rst_rnd", rnd_a, 0);
        chk("rst_rdy", rdy_a, 0);
        chk("rst_busy", busy_a, 1);
        chk("rst_empty", empty_a, 0);
        chk("rst_remain", remain_a, 0);
        tick(); tick();
        RST = 1'b0;

        // First deck, identical for both instances
        predict(0);
        for (int k = 0; k < 52; k++) deck1[k] = pred[k];
        chk("busy_held", busy_a, 1);
        wait_rdy(1'b1);
        chk("deal_entry_cycle", cyc, pred_last + 1);
        chk("entry_busy", busy_a, 0);
        chk("entry_remain", remain_a, 52);
        chk("entry_rnd", rnd_a, deck1[0]);
        chk("entry_rdy_e", rdy_e, 1);

        // Non-auto instance: deal the whole deck with single pulses
        for (int n = 0; n < 52; n++) begin
            chk("remain_e", remain_e, 52 - n);
            deal_one(1'b0, deck1[n], 51 - n, e, got);
            if (got >= 1 && got <= 13) hist[got]++;
            if (n < 51) tick();
        end
        chk("exh_empty", empty_e, 1);
        chk("exh_rdy", rdy_e, 0);
        chk("exh_busy", busy_e, 0);
        chk("exh_rnd_hold", rnd_e, deck1[51]);
        for (int r = 1; r <= 13; r++) chk($sformatf("hist_rank%0d", r), hist[r], 4);
        used_e = 1'b1;
        tick(); tick(); tick();
        used_e = 1'b0;
        chk("empty_used_remain", remain_e, 0);
        chk("empty_used_rdy", rdy_e, 0);
        chk("empty_used_empty", empty_e, 1);
        shuffle_e = 1'b1;
        e = cyc;
        tick();
        shuffle_e = 1'b0;
        chk("shuf_e_empty", empty_e, 0);
        chk("shuf_e_busy", busy_e, 1);
        predict(e + 1);
        wait_rdy(1'b0);
        chk("shuf_e_entry_cycle", cyc, pred_last + 1);
        chk("shuf_e_remain", remain_e, 52);
        chk("shuf_e_rnd", rnd_e, pred[0]);

        // Auto instance: USED held for 20 cycles gives 10 cards
        ncons = 0;
        used_a = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (rdy_a) begin
                chk("hold_rnd", rnd_a, deck1[ncons]);
                if (ncons < 8) first_cards[ncons] = int'(rnd_a);
                ncons++;
            end
            tick();
        end
        used_a = 1'b0;
        chk("hold_count", ncons, 10);
        chk("hold_remain", remain_a, 42);
        tick();
        for (int n = 10; n < 52; n++) begin
            deal_one(1'b1, deck1[n], 51 - n, e, got);
            if (n < 51) tick();
        end
        chk("auto_busy", busy_a, 1);
        chk("auto_rdy", rdy_a, 0);
        chk("auto_empty", empty_a, 0);
        predict(e + 1);
        wait_rdy(1'b1);
        chk("auto_entry_cycle", cyc, pred_last + 1);
        chk("auto_remain", remain_a, 52);
        diff = 0;
        for (int n = 0; n < 22; n++) begin
            deal_one(1'b1, pred[n], 51 - n, e, got);
            if (n < 8 && got != first_cards[n]) diff = 1;
            tick();
        end
        chk("deck2_differs", diff, 1);

        // SHUFFLE with a simultaneous consume at REMAIN=30
        chk("pre_shuf_remain", remain_a, 30);
        used_a = 1'b1;
        shuffle_a = 1'b1;
        tick();
        used_a = 1'b0;
        shuffle_a = 1'b0;
        chk("shufwin_remain", remain_a, 0);
        chk("shufwin_busy", busy_a, 1);
        chk("shufwin_rdy", rdy_a, 0);

        // Reset in the middle of the shuffle
        for (int c = 0; c < 60; c++) tick();
        chk("mid_shuf_busy", busy_a, 1);
        RST = 1'b1;
        #1;
        chk("rst2_busy", busy_a, 1);
        chk("rst2_remain_e", remain_e, 0);
        chk("rst2_rdy_e", rdy_e, 0);
        chk("rst2_rnd_e", rnd_e, 0);
        tick();
        RST = 1'b0;
        predict(0);
        wait_rdy(1'b1);
        chk("rst2_entry_cycle", cyc, pred_last + 1);
        chk("rst2_rnd", rnd_a, deck1[0]);
        chk("rst2_remain", remain_a, 52);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
